// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and constants for the APIR-DSP config-chain loader.
// The CFG_READBACK_EN build uses the CRC-8 constants and step function.
package apir_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } cfg_state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // One serial CRC-8 step, MSB-first feedback.
   function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                            input logic       d);
      logic fb;
      fb = c[7] ^ d;
      return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host configuration word stream (valid/ready).
// master = host side, slave = loader side.
interface cfg_chain_loader_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] cfg_word;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_word, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cfg_crc8_serial.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
// crc_next exposes the value after the current bit for same-cycle compares.
module cfg_crc8_serial
   import apir_cfg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc,
   output logic [7:0] crc_next
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   assign crc_next = crc8_step(crc_q, din);
   assign crc      = crc_q;

   // Clear wins over accumulate.
   always_comb begin
      crc_d = crc_q;
      if (clear)   crc_d = CRC8_INIT;
      else if (en) crc_d = crc_next;
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (!rst_n) crc_q <= CRC8_INIT;
      else        crc_q <= crc_d;
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// Scan-chain config loader: host words in, CHAIN_LEN serial bits out.
// CFG_READBACK_EN adds a CRC-checked rotate-back VERIFY pass.
module cfg_chain_loader
   import apir_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   cfg_chain_loader_if.slave cfg,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              configuration_input,
   output logic              configuration_enable,
   input  logic              configuration_output
);

   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int WC_W   = $clog2(NWORDS + 1);
   localparam int BI_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   cfg_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic [BI_W-1:0]   bidx_q, bidx_d;
   logic              bvld_q, bvld_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic              error_q, error_d;

   logic shift_act;
   logic last_bit;
   logic accept;
   logic verify_act;

   assign shift_act = (state_q == SHIFT) && bvld_q;
   assign last_bit  = shift_act &&
                      ((bidx_q == BI_W'(WORD_W - 1)) ||
                       (cnt_q == CNT_W'(1)));
   assign cfg.cfg_ready = (state_q == SHIFT) &&
                          (!bvld_q || last_bit) &&
                          (wcnt_q != WC_W'(NWORDS));
   assign accept = cfg.cfg_valid && cfg.cfg_ready;

`ifdef CFG_READBACK_EN
   logic [7:0] crc_a;
   logic [7:0] crc_b_nxt;
   logic [7:0] unused_a_nxt;
   logic [7:0] unused_b;
   logic       crc_clr;

   assign verify_act = (state_q == VERIFY);
   assign crc_clr    = (state_q == IDLE) && start;

   cfg_crc8_serial u_crc_sent (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (crc_clr),
      .en       (shift_act),
      .din      (buf_q[0]),
      .crc      (crc_a),
      .crc_next (unused_a_nxt)
   );

   cfg_crc8_serial u_crc_back (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (crc_clr),
      .en       (verify_act),
      .din      (configuration_output),
      .crc      (unused_b),
      .crc_next (crc_b_nxt)
   );
`else
   logic unused_cfg_out;
   assign verify_act     = 1'b0;
   assign unused_cfg_out = configuration_output;
`endif

   assign configuration_enable = shift_act || verify_act;
   assign configuration_input  = shift_act  ? buf_q[0] :
                                 verify_act ? configuration_output :
                                 1'b0;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign error = error_q;

   // Next state: word buffer, bit counter, sticky error.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      bidx_d  = bidx_q;
      bvld_d  = bvld_q;
      wcnt_d  = wcnt_q;
      error_d = error_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = CNT_W'(CHAIN_LEN);
               error_d = 1'b0;
               wcnt_d  = '0;
               bvld_d  = 1'b0;
               bidx_d  = '0;
            end
         end
         SHIFT: begin
            if (accept) begin
               buf_d  = cfg.cfg_word;
               bidx_d = '0;
               bvld_d = 1'b1;
               wcnt_d = wcnt_q + WC_W'(1);
            end else if (last_bit) begin
               bvld_d = 1'b0;
            end else if (shift_act) begin
               buf_d  = buf_q >> 1;
               bidx_d = bidx_q + BI_W'(1);
            end
            if (shift_act) cnt_d = cnt_q - CNT_W'(1);
            if (abort) begin
               state_d = IDLE;
               bvld_d  = 1'b0;
               buf_d   = '0;
               error_d = 1'b1;
            end else if (shift_act && cnt_q == CNT_W'(1)) begin
`ifdef CFG_READBACK_EN
               state_d = VERIFY;
               cnt_d   = CNT_W'(CHAIN_LEN);
`else
               state_d = DONE;
`endif
            end
         end
`ifdef CFG_READBACK_EN
         VERIFY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (abort) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else if (cnt_q == CNT_W'(1)) begin
               if (crc_a == crc_b_nxt) begin
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
                  error_d = 1'b1;
               end
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Loader state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         bidx_q  <= '0;
         bvld_q  <= 1'b0;
         wcnt_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         bidx_q  <= bidx_d;
         bvld_q  <= bvld_d;
         wcnt_q  <= wcnt_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a bit-level scoreboard.
// Two instances: CHAIN_LEN=1 and a two-word chain (48, or 64 with CFG_READBACK_EN).
module tb_cfg_chain_loader;

   localparam int WW = 32;
`ifdef CFG_READBACK_EN
   localparam int XL = 64;
   localparam int RB = 2;
`else
   localparam int XL = 48;
   localparam int RB = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start1, abort1, busy1, done1, err1, ci1, ce1, co1;
   logic startx, abortx, busyx, donex, errx, cix, cex, cox;
   logic          chain1 = 1'b0;
   logic [XL-1:0] chainx = '0;
   logic          stuck  = 1'b0;

   int checks = 0;
   int errors = 0;
   bit sb[$];

   cfg_chain_loader_if #(.WORD_W(WW)) if1 ();
   cfg_chain_loader_if #(.WORD_W(WW)) ifx ();

   assign co1 = chain1;
   assign cox = chainx[XL-1];

   cfg_chain_loader #(.CHAIN_LEN(1), .WORD_W(WW)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .cfg(if1), .busy(busy1), .done(done1), .error(err1),
      .configuration_input(ci1), .configuration_enable(ce1),
      .configuration_output(co1)
   );

   cfg_chain_loader #(.CHAIN_LEN(XL), .WORD_W(WW)) ux (
      .clk(clk), .rst_n(rst_n), .start(startx), .abort(abortx),
      .cfg(ifx), .busy(busyx), .done(donex), .error(errx),
      .configuration_input(cix), .configuration_enable(cex),
      .configuration_output(cox)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Chain models (head = position 0) and per-bit scoreboard.
   always @(negedge clk) begin
      bit want;
      if (ce1) chain1 <= ci1;
      if (cex) begin
         chainx <= {chainx[XL-2:0], cix & ~stuck};
         if (sb.size() > 0) begin
            want = sb.pop_front();
            chk("sb_bit", cix, want);
         end
      end
   end

   task automatic feed_word(input logic [31:0] w, input int nbits,
                            input int hold, input bit chk_en);
      bit ok;
      ifx.cfg_word  = w;
      ifx.cfg_valid = 1'b0;
      if (hold > 0) begin
         ok = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifx.cfg_ready) begin ok = 1; break; end
         end
         chk("stall_ready_seen", ok, 1);
         repeat (hold) @(posedge clk);
         #1;
      end
      ifx.cfg_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ifx.cfg_ready) begin ok = 1; break; end
      end
      chk("accept_seen", ok, 1);
      if (chk_en) chk("b2b_accept_en", cex, 1);
      for (int i = 0; i < nbits; i++) sb.push_back(w[i]);
      @(posedge clk);
      #1;
      ifx.cfg_valid = 1'b0;
   endtask

   task automatic run_x(input int budget, output int ens, output int gaps,
                        output int lat, output bit d);
      int last;
      ens = 0; gaps = 0; lat = -1; d = 0; last = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cex) begin
            ens++;
            last = i;
         end else if (donex) begin
            d   = 1;
            lat = i - last;
            break;
         end else if (ens > 0 && !busyx) begin
            break;
         end else if (ens > 0) begin
            gaps++;
         end
      end
   endtask

   task automatic start_x();
      @(posedge clk); #1 startx = 1'b1;
      @(posedge clk); #1 startx = 1'b0;
   endtask

   task automatic load_x(input string tg, input logic [31:0] w0,
                         input logic [31:0] w1, input int hold,
                         input bit want_done);
      int ens, gaps, lat;
      bit d;
      logic [63:0]   s;
      logic [XL-1:0] want;
      start_x();
      chk({tg, "_err_clr"}, errx, 0);
      chk({tg, "_busy"}, busyx, 1);
      fork
         begin
            feed_word(w0, 32, 0, 1'b0);
            feed_word(w1, XL - 32, hold, hold == 0);
         end
         run_x(600, ens, gaps, lat, d);
      join
      chk({tg, "_en_count"}, ens, RB * XL);
      chk({tg, "_stall"}, gaps, hold);
      chk({tg, "_done"}, d, want_done);
      chk({tg, "_error"}, errx, !want_done);
      chk({tg, "_sb_empty"}, sb.size(), 0);
      s = {w1, w0};
      for (int k = 0; k < XL; k++) want[XL-1-k] = s[k];
      if (want_done) begin
         chk({tg, "_done_lat"}, lat, 1);
         chk({tg, "_chain"}, chainx, want);
      end
   endtask

   initial begin
      int  n, ens, last, dc;
      bit  ok, seen, first_in;
      rst_n = 1'b0;
      start1 = 0; abort1 = 0; startx = 0; abortx = 0;
      if1.cfg_word = '0; if1.cfg_valid = 0;
      ifx.cfg_word = '0; ifx.cfg_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {busy1, busyx}, 0);
      chk("rst_done", {done1, donex}, 0);
      chk("rst_err", {err1, errx}, 0);
      chk("rst_en_in", {ce1, ci1, cex, cix}, 0);
      chk("rst_ready", {if1.cfg_ready, ifx.cfg_ready}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // CHAIN_LEN=1: single XORSIMD bit.
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      if1.cfg_word = 32'h0000_0001; if1.cfg_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if1.cfg_ready) begin ok = 1; break; end
      end
      chk("u1_accept", ok, 1);
      @(posedge clk); #1 if1.cfg_valid = 1'b0;
      ens = 0; seen = 0; first_in = 0; last = 0; dc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ce1) begin
            if (ens == 0) first_in = ci1;
            ens++;
            last = i;
         end
         if (done1) begin seen = 1; dc = i; break; end
      end
      chk("u1_en_count", ens, RB);
      chk("u1_in", first_in, 1);
      chk("u1_done", seen, 1);
      chk("u1_done_lat", dc - last, 1);
      chk("u1_xorsimd", chain1, 1);
      chk("u1_err", err1, 0);

      load_x("b2b", 32'hDEAD_BEEF, 32'h0000_CAFE, 0, 1'b1);
      load_x("stall", 32'h0F0F_1234, 32'h0000_5A5A, 5, 1'b1);

      // Abort after 10 enables.
      start_x();
      fork
         feed_word(32'h1234_5678, 32, 0, 1'b0);
         begin
            n = 0;
            for (int i = 0; i < 100 && n < 10; i++) begin
               @(negedge clk);
               if (cex) n++;
            end
            chk("abort_pre_en", n, 10);
            @(posedge clk); #1 abortx = 1'b1;
            @(posedge clk); #1 abortx = 1'b0;
            @(negedge clk);
            chk("abort_en", cex, 0);
            chk("abort_err", errx, 1);
            chk("abort_busy", busyx, 0);
            chk("abort_done", donex, 0);
         end
      join
      sb.delete();
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (donex) seen = 1;
      end
      chk("abort_no_done", seen, 0);
      load_x("post_abort", 32'hA5A5_0F0F, 32'h0000_C3C3, 0, 1'b1);

      // Reset mid-SHIFT.
      start_x();
      fork
         feed_word(32'hFFFF_FFFF, 32, 0, 1'b0);
         begin
            n = 0;
            for (int i = 0; i < 100 && n < 5; i++) begin
               @(negedge clk);
               if (cex) n++;
            end
            chk("rst_pre_en", n, 5);
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_rst_en_in", {cex, cix}, 0);
            chk("mid_rst_flags", {busyx, donex, errx}, 0);
            chk("mid_rst_ready", ifx.cfg_ready, 0);
         end
      join
      @(posedge clk); #1 rst_n = 1'b1;
      sb.delete();
      load_x("post_rst", 32'h8000_0001, 32'h0000_7E81, 0, 1'b1);

`ifdef CFG_READBACK_EN
      // Head register stuck at 0 under a loaded 1.
      stuck = 1'b1;
      load_x("stuck", 32'h0000_0000, 32'h8000_0000, 0, 1'b0);
      stuck = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
